crc16_frame_chk: RTL

Frame-level controller in front of the 32-bit CRC16 receive checker core (sync active-low init, 1-cycle result latency).
- Accepts framed 32-bit words from the upstream deserializer and re-initialises the core at every frame start.
- Forwards each word to the core, captures the final residual one cycle after the last word, and reports frame good/bad.
- Keeps saturating good/bad frame counters for status registers.

---
 rtl/crc16_frame_chk.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/crc16_frame_chk.sv
// Frame controller for the 32-bit CRC16 receive checker core.
// Optional sticky error flag: CRC_FRAME_CHK_STICKY_ERR_EN.
module crc16_frame_chk #(
  parameter int MIN_WORDS = 2,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk_r,
  input  logic             i_rst_r,
  input  logic             i_din_valid,
  input  logic [31:0]      i_din,
  input  logic             i_din_last,
  output logic             o_din_ready,
  output logic             o_crc_rst_n,
  output logic             o_crc_din_valid,
  output logic [31:0]      o_crc_din,
  input  logic             i_crc_valid,
  input  logic [15:0]      i_crc,
  output logic             o_frame_done,
  output logic             o_frame_ok,
  output logic             o_len_err,
  output logic [CNT_W-1:0] o_good_cnt,
  output logic [CNT_W-1:0] o_bad_cnt,
  output logic             o_busy
`ifdef CRC_FRAME_CHK_STICKY_ERR_EN
  ,
  input  logic             i_err_clr,
  output logic             o_err_sticky
`endif
);

  localparam int LW = $clog2(MAX_WORDS + 2);
  localparam logic [LW-1:0] MINC = LW'(MIN_WORDS);
  localparam logic [LW-1:0] MAXC = LW'(MAX_WORDS);
  localparam logic [LW-1:0] MAX1 = LW'(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_WAIT, S_REPORT
  } state_t;

  state_t state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic armed_q, armed_d;
  logic [1:0] wd_q, wd_d;
  logic vld_q, vld_d;
  logic [31:0] dat_q, dat_d;
  logic done_q, done_d;
  logic ok_q, ok_d;
  logic lerr_q, lerr_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic xfer, capture, tmo, len_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    armed_d = armed_q;
    wd_d    = wd_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    lerr_d  = lerr_q;
    good_d  = good_q;
    bad_d   = bad_q;
    xfer    = i_din_valid & (state_q == S_RUN);
    capture = (state_q == S_WAIT) & armed_q & i_crc_valid;
    tmo     = (state_q == S_WAIT) & (wd_q == 2'd3);
    len_bad = ovf_q | (cnt_q < MINC);
    unique case (state_q)
      S_IDLE: state_d = S_INIT;
      S_INIT: begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        armed_d = 1'b0;
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer) begin
          if (cnt_q != MAX1) cnt_d = cnt_q + LW'(1);
          // words past the legal maximum are swallowed, not fed to the core
          if (cnt_q >= MAXC) begin
            ovf_d = 1'b1;
          end else begin
            vld_d = 1'b1;
            dat_d = i_din;
          end
          if (i_din_last) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + 2'd1;
        // arm only once the last word has actually reached the core
        if (vld_q) armed_d = 1'b1;
        if (ovf_q | capture | tmo) begin
          state_d = S_REPORT;
          done_d  = 1'b1;
          lerr_d  = len_bad;
          ok_d    = capture & ~len_bad & (i_crc == 16'h0000);
          if (ok_d) begin
            if (~&good_q) good_d = good_q + CNT_W'(1);
          end else begin
            if (~&bad_q) bad_d = bad_q + CNT_W'(1);
          end
        end
      end
      S_REPORT: state_d = S_INIT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_r) begin
    if (i_rst_r) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
      wd_q    <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      lerr_q  <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
      wd_q    <= wd_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      lerr_q  <= lerr_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

`ifdef CRC_FRAME_CHK_STICKY_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (i_err_clr) err_d = 1'b0;
    if (done_d & ~ok_d) err_d = 1'b1;
  end

  always_ff @(posedge i_clk_r) begin
    if (i_rst_r) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign o_err_sticky = err_q;
`endif

  assign o_din_ready     = (state_q == S_RUN);
  assign o_crc_rst_n     = (state_q == S_RUN) |
                           (state_q == S_WAIT) |
                           (state_q == S_REPORT);
  assign o_crc_din_valid = vld_q;
  assign o_crc_din       = dat_q;
  assign o_frame_done    = done_q;
  assign o_frame_ok      = ok_q;
  assign o_len_err       = lerr_q;
  assign o_good_cnt      = good_q;
  assign o_bad_cnt       = bad_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule
